rr_stream_mux: RTL

- Parametrised N-channel, W-bit streaming multiplexer. Successor to the fixed 2:1/4:1 combinational muxes.
- Selection comes from a round-robin arbiter over valid/ready channels, not from an external select.
- Registered single-stage output; optional packet-lock mode holds the grant for multi-beat transfers.
- Sits between multiple producer blocks and one shared consumer (e.g. a shared bus or FIFO write port).

---
 rtl/rr_stream_mux.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rr_stream_mux.sv
// N-channel round-robin valid/ready stream multiplexer with one registered output stage.
// Optional packet lock keeps the grant on one channel until its last beat transfers.
module rr_stream_mux #(
    parameter int WIDTH    = 8,
    parameter int NUM_CH   = 4,
    parameter int LOCK_PKT = 0,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CH*WIDTH-1:0] i_data,
    input  logic [NUM_CH-1:0]       i_valid,
    input  logic [NUM_CH-1:0]       i_last,
    output logic [NUM_CH-1:0]       o_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_valid,
    output logic                    o_last,
    output logic [SEL_W-1:0]        o_ch,
    input  logic                    i_ready
);

    logic [WIDTH-1:0] ch_data [NUM_CH];

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;
    logic             o_last_q, o_last_d;
    logic [SEL_W-1:0] o_ch_q, o_ch_d;

    logic [SEL_W-1:0] rr_grant;
    logic             rr_found;
    logic             locked;
    logic [SEL_W-1:0] lock_ch;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic             load_en;
    logic             in_xfer;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_data[k] = i_data[k*WIDTH +: WIDTH];
        end
    end

    // Rotating priority: first valid channel at or after ptr, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rr_found && i_valid[(int'(ptr_q) + i) % NUM_CH]) begin
                rr_found = 1'b1;
                rr_grant = SEL_W'((int'(ptr_q) + i) % NUM_CH);
            end
        end
    end

    assign grant     = locked ? lock_ch : rr_grant;
    assign grant_vld = locked | rr_found;
    assign load_en   = !o_valid_q || i_ready;
    assign in_xfer   = load_en && grant_vld && i_valid[grant];

    always_comb begin
        o_ready = '0;
        if (i_rst_n && load_en && grant_vld) begin
            o_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_last_d  = o_last_q;
        o_ch_d    = o_ch_q;
        ptr_d     = ptr_q;
        if (load_en) begin
            o_valid_d = in_xfer;
            if (in_xfer) begin
                o_data_d = ch_data[grant];
                o_last_d = i_last[grant];
                o_ch_d   = grant;
                // While locked grant never moves, so ptr stays at lock_ch+1.
                ptr_d    = (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
            o_ch_q    <= '0;
            ptr_q     <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_last_q  <= o_last_d;
            o_ch_q    <= o_ch_d;
            ptr_q     <= ptr_d;
        end
    end

    if (LOCK_PKT != 0) begin : g_lock
        localparam logic [0:0] ST_IDLE   = 1'b0;
        localparam logic [0:0] ST_LOCKED = 1'b1;

        logic [0:0]       state_q, state_d;
        logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

        always_comb begin
            state_d   = state_q;
            lock_ch_d = lock_ch_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (in_xfer && !i_last[grant]) begin
                        state_d   = ST_LOCKED;
                        lock_ch_d = grant;
                    end
                end
                ST_LOCKED: begin
                    if (in_xfer && i_last[grant]) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q   <= ST_IDLE;
                lock_ch_q <= '0;
            end else begin
                state_q   <= state_d;
                lock_ch_q <= lock_ch_d;
            end
        end

        assign locked  = (state_q == ST_LOCKED);
        assign lock_ch = lock_ch_q;
    end else begin : g_nolock
        assign locked  = 1'b0;
        assign lock_ch = '0;
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_last  = o_last_q;
    assign o_ch    = o_ch_q;

    a_ready_onehot: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) $onehot0(o_ready));

    a_hold_stable: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (o_valid && !i_ready) |=> (o_valid && $stable(o_data)));

endmodule
